clarvi_load_return: RTL and testbench
=====================================

Name: clarvi_load_return

Overview:
- Consumes memory read responses for loads issued by the memory-access (MMU) stage.
- Tracks one outstanding load and holds its context (byte offset, width, signedness, destination register) until data returns.
- Aligns the returned 64-bit word, then zero- or sign-extends it, and presents the result to writeback.
- Generates the `stall_for_memory_pending` back-pressure that the issuing stage uses to gate new memory requests.

Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles waited for a response (used only with `CLARVI_LOAD_TIMEOUT_EN`).
- `TIMEOUT_WIDTH`, 8: width of the timeout counter; must satisfy 2^`TIMEOUT_WIDTH` > `TIMEOUT_CYCLES`.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  pipeline stall; an issue is accepted only when low.
- `issue`  in  1  load issued this cycle (driven from `main_read_enable`).
- `issue_offset`  in  3  byte offset within the 64-bit word (`word_offset`).
- `issue_width`  in  2  `mem_width_t`: B=0, H=1, W=2, D=3.
- `issue_unsigned`  in  1  1 = zero-extend (LBU/LHU/LWU).
- `issue_rd`  in  5  destination register.
- `mem_read_data`  in  64  read response data.
- `mem_read_valid`  in  1  response strobe, one cycle per response.
- `wb_stall`  in  1  writeback cannot accept a result this cycle.
- `load_valid`  out  1  result available.
- `load_data`  out  64  aligned, extended result.
- `load_rd`  out  5  destination register of the result.
- `stall_for_memory_pending`  out  1  issuing stage must not issue a memory access.
- `load_error`  out  1  response timeout (see Optional Feature).

Behaviour:
- The block has three states: IDLE, WAIT, DONE.
- Reset values: state=IDLE, `load_valid`=0, `load_data`=0, `load_rd`=0, `load_error`=0, context registers=0, timeout counter=0.
- An issue is accepted when `issue` && !`stall` && (state==IDLE || (state==DONE && !`wb_stall`)).
  - On accept: capture offset, width, unsigned flag and rd; next state = WAIT.
- WAIT, `mem_read_valid`=1:
  - `load_data` <= extend(`mem_read_data` >> (offset*8)); `load_rd` <= captured rd; `load_valid` <= 1; next state = DONE.
  - Latency from response to `load_valid` is exactly 1 cycle.
  - A response arriving in the same cycle as the issue is not possible; the minimum response latency is 1 cycle after issue.
- DONE:
  - `load_valid`=1 and `load_data`/`load_rd` are held stable while `wb_stall`=1.
  - In the first cycle with `wb_stall`=0 the result is consumed: go to IDLE, or to WAIT if a new issue is accepted in that same cycle (back-to-back loads).
- Extension rules, applied to the shifted word s:
  - B: bits [7:0] of s.
  - H: bits [15:0] of s.
  - W: bits [31:0] of s.
  - D: all 64 bits of s.
  - Sign-extend from the field MSB unless `issue_unsigned`=1; D ignores `issue_unsigned`.
  - Bits shifted in from above bit 63 are zero before extension.
- `stall_for_memory_pending` (combinational) = (state==WAIT) || (state==DONE && `wb_stall`).
- `mem_read_valid` in IDLE or DONE is a spurious response: ignored, with no state change and no output change.
- `issue` while in WAIT, or in DONE with `wb_stall`=1, is a protocol violation: ignored. The bench flags it with an assertion.
- Reset mid-WAIT or mid-DONE returns to IDLE and clears `load_valid`. A response arriving after reset is treated as spurious and ignored.
- Offset is not checked for alignment; misaligned accesses are rejected upstream. A field that crosses bit 63 yields truncated-then-extended data, which is deterministic.

Optional Feature:
- Macro: `CLARVI_LOAD_TIMEOUT_EN`.
- Defined:
  - The counter clears on entry to WAIT and increments each WAIT cycle without `mem_read_valid`.
  - When it reaches `TIMEOUT_CYCLES`, the block goes to DONE with `load_data`=0, `load_valid`=1, and `load_error`=1 for exactly that result.
  - `load_error` clears when the result is consumed.
- Not defined: no counter is present, WAIT waits indefinitely, and `load_error` is tied to 0.

Test Plan:
1. Issue LB with offset=3, signed, rd=5; respond 2 cycles later with data 0x0000_0000_8000_0000 → `load_valid` 1 cycle after the response, `load_data`=0xFFFF_FFFF_FFFF_FF80, `load_rd`=5; `stall_for_memory_pending`=1 throughout WAIT.
2. Issue LHU, offset=6, data 0xBEEF_0000_0000_0000 → `load_data`=0x0000_0000_0000_BEEF. Issue LW, offset=4, same data → `load_data`=0xFFFF_FFFF_BEEF_0000. Issue LD, offset=0, data 0x1234_5678_9ABC_DEF0 → `load_data`=0x1234_5678_9ABC_DEF0.
3. Hold `wb_stall`=1 for 3 cycles in DONE → `load_valid`/`load_data`/`load_rd` unchanged and `stall_for_memory_pending`=1; release `wb_stall` with `issue`=1 → the new load is accepted (WAIT) the next cycle with no bubble.
4. Pulse `mem_read_valid` in IDLE with data 0xFF; separately, assert `issue` with `stall`=1 → no state change, `load_valid` stays 0.
5. Assert `reset` 1 cycle into WAIT, then deliver a response → state=IDLE and `load_valid` never asserts.
6. With `CLARVI_LOAD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, issue and withhold the response → after 4 WAIT cycles `load_valid`=1, `load_error`=1, `load_data`=0; both clear when the result is consumed.

Source files
------------

// File: rtl/clarvi_load_return_if.sv
// clarvi_load_return_if: groups the issue, memory-response and writeback signals of the load-return block.
//   master : issuing/memory/writeback side, drives stall, issue*, mem_read_*, wb_stall
//   slave  : clarvi_load_return, drives load_valid, load_data, load_rd, stall_for_memory_pending, load_error
interface clarvi_load_return_if;
    logic        stall;
    logic        issue;
    logic [2:0]  issue_offset;
    logic [1:0]  issue_width;
    logic        issue_unsigned;
    logic [4:0]  issue_rd;
    logic [63:0] mem_read_data;
    logic        mem_read_valid;
    logic        wb_stall;
    logic        load_valid;
    logic [63:0] load_data;
    logic [4:0]  load_rd;
    logic        stall_for_memory_pending;
    logic        load_error;

    modport master (
        output stall, issue, issue_offset, issue_width, issue_unsigned, issue_rd,
        output mem_read_data, mem_read_valid, wb_stall,
        input  load_valid, load_data, load_rd, stall_for_memory_pending, load_error
    );

    modport slave (
        input  stall, issue, issue_offset, issue_width, issue_unsigned, issue_rd,
        input  mem_read_data, mem_read_valid, wb_stall,
        output load_valid, load_data, load_rd, stall_for_memory_pending, load_error
    );
endinterface

// File: rtl/clarvi_load_return.sv
// clarvi_load_return: tracks one outstanding load, aligns and extends its returned word for writeback.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : issue context in, memory response in, wb_stall in;
//                  load_valid/load_data/load_rd result out, stall_for_memory_pending and load_error out
//   Optional macro CLARVI_LOAD_TIMEOUT_EN adds a response timeout (TIMEOUT_CYCLES, TIMEOUT_WIDTH);
//   without it WAIT waits indefinitely and load_error is tied low.
module clarvi_load_return
`ifdef CLARVI_LOAD_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
)
`endif
(
    input logic                 clock,
    input logic                 reset,
    clarvi_load_return_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {B, H, W, D} mem_width_t;

    state_t      state, next_state;
    logic [2:0]  ctx_offset;
    mem_width_t  ctx_width;
    logic        ctx_unsigned;
    logic [4:0]  ctx_rd;
    logic        accept, respond, timeout, fill;
    logic [63:0] shifted, extended;

    // a finished result frees the slot in the same cycle writeback takes it
    assign accept  = bus.issue && !bus.stall && (state == IDLE || (state == DONE && !bus.wb_stall));
    // responses outside WAIT are spurious and never reach the outputs
    assign respond = state == WAIT && bus.mem_read_valid;
    assign bus.stall_for_memory_pending = state == WAIT || (state == DONE && bus.wb_stall);

`ifdef CLARVI_LOAD_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wait_count;
    logic                     error_q;
    // the last silent WAIT cycle is the one where the count would reach TIMEOUT_CYCLES
    assign timeout = state == WAIT && !bus.mem_read_valid && wait_count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    assign bus.load_error = error_q;
    always_ff @(posedge clock) begin
        if (reset || accept)
            wait_count <= '0;
        else if (state == WAIT && !bus.mem_read_valid)
            wait_count <= wait_count + 1'b1;
        if (reset)
            error_q <= 1'b0;
        else if (timeout)
            error_q <= 1'b1;
        else if (state == DONE && !bus.wb_stall)
            error_q <= 1'b0;
    end
`else
    assign timeout = 1'b0;
    assign bus.load_error = 1'b0;
`endif

    // bits above 63 shift in as zero, so fields crossing the top are truncated before extension
    always_comb begin
        shifted  = bus.mem_read_data >> {ctx_offset, 3'b000};
        fill     = !ctx_unsigned && (ctx_width == B ? shifted[7] : ctx_width == H ? shifted[15] : shifted[31]);
        extended = ctx_width == B ? {{56{fill}}, shifted[7:0]} :
                   ctx_width == H ? {{48{fill}}, shifted[15:0]} :
                   ctx_width == W ? {{32{fill}}, shifted[31:0]} : shifted;
    end

    always_comb begin
        next_state = state;
        if (accept)
            next_state = WAIT;
        else if (respond || timeout)
            next_state = DONE;
        else if (state == DONE && !bus.wb_stall)
            next_state = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            ctx_offset     <= '0;
            ctx_width      <= B;
            ctx_unsigned   <= 1'b0;
            ctx_rd         <= '0;
            bus.load_valid <= 1'b0;
            bus.load_data  <= '0;
            bus.load_rd    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                ctx_offset   <= bus.issue_offset;
                ctx_width    <= mem_width_t'(bus.issue_width);
                ctx_unsigned <= bus.issue_unsigned;
                ctx_rd       <= bus.issue_rd;
            end
            if (respond || timeout) begin
                bus.load_valid <= 1'b1;
                bus.load_data  <= respond ? extended : '0;
                bus.load_rd    <= ctx_rd;
            end else if (state == DONE && !bus.wb_stall) begin
                bus.load_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clarvi_load_return.sv
// tb_clarvi_load_return: table-driven, hand-sequenced and randomized checks of clarvi_load_return.
module tb_clarvi_load_return;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    clarvi_load_return_if bus ();

`ifdef CLARVI_LOAD_TIMEOUT_EN
    clarvi_load_return #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(3)) dut (.clock(clock), .reset(reset), .bus(bus));
`else
    clarvi_load_return dut (.clock(clock), .reset(reset), .bus(bus));
`endif

    always #5 clock = ~clock;

    // issuing while the block reports memory pending breaks the protocol
    always @(posedge clock)
        if (!reset && bus.issue && !bus.stall)
            assert (!bus.stall_for_memory_pending) else $error("protocol: issue while memory access pending");

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  off;
        logic [1:0]  w;
        logic        uns;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];

    // reference: take the field arithmetically, then wrap negative values into two's complement
    function automatic logic [63:0] ref_ext(input logic [63:0] d, input int off, input int w, input bit uns);
        int          bits = 8 << w;
        logic [63:0] s = d >> (8 * off);
        logic [63:0] f;
        if (bits == 64) return s;
        f = s & ((64'd1 << bits) - 64'd1);
        if (!uns && f[bits-1]) f = f - (64'd1 << bits);
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_load(input logic [2:0] off, input logic [1:0] w, input logic uns, input logic [4:0] rd);
        bus.issue_offset   = off;
        bus.issue_width    = w;
        bus.issue_unsigned = uns;
        bus.issue_rd       = rd;
        bus.issue          = 1'b1;
        cyc();
        bus.issue          = 1'b0;
    endtask

    task automatic respond(input logic [63:0] data);
        bus.mem_read_data  = data;
        bus.mem_read_valid = 1'b1;
        cyc();
        bus.mem_read_valid = 1'b0;
        bus.mem_read_data  = {$urandom, $urandom};
    endtask

    task automatic check_result(input string name, input logic [63:0] exp, input logic [4:0] rd);
        check({name, " valid"}, 64'(bus.load_valid), 64'd1);
        check({name, " data"}, bus.load_data, exp);
        check({name, " rd"}, 64'(bus.load_rd), 64'(rd));
        check({name, " error"}, 64'(bus.load_error), 64'd0);
    endtask

    logic [2:0]  r_off;
    logic [1:0]  r_w;
    logic        r_uns;
    logic [4:0]  r_rd;
    logic [63:0] r_data;

    task automatic gen_tx();
        r_off  = 3'($urandom_range(0, 7));
        r_w    = 2'($urandom_range(0, 3));
        r_uns  = 1'($urandom_range(0, 1));
        r_rd   = 5'($urandom_range(0, 31));
        r_data = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) r_data = r_data | 64'h8080_8080_8080_8080;
    endtask

    initial begin
        logic [63:0] last;
        vecs[0] = '{3'd3, 2'd0, 1'b0, 5'd5,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{3'd6, 2'd1, 1'b1, 5'd7,  64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF};
        vecs[2] = '{3'd4, 2'd2, 1'b0, 5'd8,  64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_BEEF_0000};
        vecs[3] = '{3'd0, 2'd3, 1'b0, 5'd9,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
        vecs[4] = '{3'd7, 2'd0, 1'b1, 5'd1,  64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB};
        vecs[5] = '{3'd6, 2'd2, 1'b0, 5'd2,  64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001};
        vecs[6] = '{3'd1, 2'd3, 1'b1, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_FFFF_FFFF};
        vecs[7] = '{3'd2, 2'd1, 1'b0, 5'd31, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001};
        vecs[8] = '{3'd5, 2'd0, 1'b0, 5'd0,  64'h0000_7F00_0000_0000, 64'h0000_0000_0000_007F};

        bus.stall = 0; bus.issue = 0; bus.issue_offset = 0; bus.issue_width = 0;
        bus.issue_unsigned = 0; bus.issue_rd = 0; bus.mem_read_data = 0;
        bus.mem_read_valid = 0; bus.wb_stall = 0;
        cyc();
        cyc();
        check("reset valid", 64'(bus.load_valid), 64'd0);
        check("reset data", bus.load_data, 64'd0);
        check("reset rd", 64'(bus.load_rd), 64'd0);
        check("reset error", 64'(bus.load_error), 64'd0);
        check("reset pending", 64'(bus.stall_for_memory_pending), 64'd0);
        reset = 1'b0;
        cyc();

        // table: issue, one silent WAIT cycle, respond, consume
        for (int i = 0; i < 9; i++) begin
            issue_load(vecs[i].off, vecs[i].w, vecs[i].uns, vecs[i].rd);
            check($sformatf("vec%0d wait pending", i), 64'(bus.stall_for_memory_pending), 64'd1);
            check($sformatf("vec%0d wait valid", i), 64'(bus.load_valid), 64'd0);
            cyc();
            check($sformatf("vec%0d wait2 pending", i), 64'(bus.stall_for_memory_pending), 64'd1);
            respond(vecs[i].data);
            check_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].rd);
            cyc();
            check($sformatf("vec%0d consumed", i), 64'(bus.load_valid), 64'd0);
        end
        last = vecs[8].exp;

        // writeback back-pressure, spurious response in DONE, then back-to-back issue
        issue_load(3'd2, 2'd1, 1'b1, 5'd11);
        respond(64'h0000_0000_CAFE_0000);
        check_result("hold", 64'h0000_0000_0000_CAFE, 5'd11);
        bus.wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d pending", k), 64'(bus.stall_for_memory_pending), 64'd1);
            bus.mem_read_valid = (k == 1);
            bus.mem_read_data  = 64'hFFFF_FFFF_FFFF_FFFF;
            cyc();
            bus.mem_read_valid = 1'b0;
            check($sformatf("hold%0d valid", k), 64'(bus.load_valid), 64'd1);
            check($sformatf("hold%0d data", k), bus.load_data, 64'h0000_0000_0000_CAFE);
            check($sformatf("hold%0d rd", k), 64'(bus.load_rd), 64'd11);
        end
        bus.wb_stall = 1'b0;
        #1;
        check("release pending", 64'(bus.stall_for_memory_pending), 64'd0);
        issue_load(3'd0, 2'd3, 1'b0, 5'd12);
        check("b2b consumed", 64'(bus.load_valid), 64'd0);
        check("b2b pending", 64'(bus.stall_for_memory_pending), 64'd1);
        respond(64'hFEDC_BA98_7654_3210);
        check_result("b2b", 64'hFEDC_BA98_7654_3210, 5'd12);
        last = 64'hFEDC_BA98_7654_3210;
        cyc();

        // spurious response in IDLE and an issue blocked by stall
        respond(64'h0000_0000_0000_00FF);
        check("spurious valid", 64'(bus.load_valid), 64'd0);
        check("spurious data", bus.load_data, last);
        bus.stall = 1'b1;
        issue_load(3'd0, 2'd3, 1'b0, 5'd13);
        bus.stall = 1'b0;
        check("stalled pending", 64'(bus.stall_for_memory_pending), 64'd0);
        respond(64'h0000_0000_0000_0055);
        check("stalled valid", 64'(bus.load_valid), 64'd0);
        check("stalled data", bus.load_data, last);

        // reset during WAIT, late response must be ignored
        issue_load(3'd0, 2'd3, 1'b0, 5'd14);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst pending", 64'(bus.stall_for_memory_pending), 64'd0);
        respond(64'h1111_2222_3333_4444);
        check("rst valid", 64'(bus.load_valid), 64'd0);
        check("rst data", bus.load_data, 64'd0);
        cyc();
        check("rst valid2", 64'(bus.load_valid), 64'd0);

`ifdef CLARVI_LOAD_TIMEOUT_EN
        issue_load(3'd0, 2'd3, 1'b0, 5'd15);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("to wait%0d valid", k), 64'(bus.load_valid), 64'd0);
        end
        cyc();
        check("to valid", 64'(bus.load_valid), 64'd1);
        check("to error", 64'(bus.load_error), 64'd1);
        check("to data", bus.load_data, 64'd0);
        check("to rd", 64'(bus.load_rd), 64'd15);
        cyc();
        check("to consumed valid", 64'(bus.load_valid), 64'd0);
        check("to consumed error", 64'(bus.load_error), 64'd0);
`endif

        // randomized transactions against the reference model
        gen_tx();
        issue_load(r_off, r_w, r_uns, r_rd);
        for (int i = 0; i < 150; i++) begin
            logic [63:0] exp;
            exp = ref_ext(r_data, int'(r_off), int'(r_w), r_uns);
            repeat ($urandom_range(0, 3)) begin
                check("rnd wait pending", 64'(bus.stall_for_memory_pending), 64'd1);
                cyc();
            end
            respond(r_data);
            check_result($sformatf("rnd%0d", i), exp, r_rd);
            bus.wb_stall = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                bus.mem_read_valid = 1'($urandom_range(0, 1));
                cyc();
                bus.mem_read_valid = 1'b0;
                check("rnd hold data", bus.load_data, exp);
                check("rnd hold valid", 64'(bus.load_valid), 64'd1);
            end
            bus.wb_stall = 1'b0;
            if (i < 149 && $urandom_range(0, 1) == 1) begin
                gen_tx();
                issue_load(r_off, r_w, r_uns, r_rd);
                check("rnd b2b valid", 64'(bus.load_valid), 64'd0);
            end else begin
                cyc();
                check("rnd idle valid", 64'(bus.load_valid), 64'd0);
                check("rnd idle pending", 64'(bus.stall_for_memory_pending), 64'd0);
                if (i < 149) begin
                    gen_tx();
                    issue_load(r_off, r_w, r_uns, r_rd);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
